// File: rtl/breath_led_array.sv
// Multi-channel breathing-LED PWM generator: one shared period counter, per-channel
// saturating duty ramps, per-channel mode (off/on/breathe/freeze), polarity and global enable.
module breath_led_array #(
  parameter int unsigned CH_NUM     = 4,
  parameter int unsigned PWM_PERIOD = 100000,
  parameter int unsigned CNT_W      = 17,
  parameter int unsigned STEP       = 50,
  parameter int unsigned PHASE_EN   = 1,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  en,
  input  logic [2*CH_NUM-1:0]   mode,
  output logic [CH_NUM-1:0]     led,
  output logic                  period_tick,
  output logic                  breath_done
);

  localparam int unsigned EXT_W      = CNT_W + 1;
  localparam int unsigned PHASE_STEP = PWM_PERIOD / CH_NUM;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_PERIOD - 1);
  localparam logic [CNT_W-1:0] DUTY_MAX = CNT_W'(PWM_PERIOD);
  localparam logic [CNT_W:0]   PERIOD_X = EXT_W'(PWM_PERIOD);
  localparam logic [CNT_W:0]   STEP_X   = EXT_W'(STEP);
  localparam logic             INACTIVE = (ACTIVE_LOW != 0);

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_ON      = 2'b01;
  localparam logic [1:0] MODE_BREATHE = 2'b10;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  logic [CNT_W-1:0]  period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0]  duty_q [CH_NUM];
  logic [CNT_W-1:0]  duty_d [CH_NUM];
  logic [CH_NUM-1:0] dir_q, dir_d;
  logic [CH_NUM-1:0] led_q, led_d;
  logic              period_tick_q, period_tick_d;
  logic              breath_done_q, breath_done_d;

  logic              period_end_c;
  logic [1:0]        mode_ch;
  logic              lit;
  logic [CNT_W:0]    duty_ext;

  assign period_end_c = en && (period_cnt_q == CNT_LAST);

  // Next-state: counter wrap, per-channel ramp with saturation at both endpoints, pin levels.
  always_comb begin
    period_cnt_d  = period_cnt_q;
    duty_d        = duty_q;
    dir_d         = dir_q;
    led_d         = {CH_NUM{INACTIVE}};
    period_tick_d = 1'b0;
    breath_done_d = 1'b0;
    mode_ch       = MODE_OFF;
    lit           = 1'b0;
    duty_ext      = '0;

    if (en) begin
      period_cnt_d  = period_end_c ? '0 : period_cnt_q + CNT_W'(1);
      period_tick_d = period_end_c;

      for (int i = 0; i < int'(CH_NUM); i++) begin
        mode_ch  = mode[2*i +: 2];
        duty_ext = {1'b0, duty_q[i]};

        case (mode_ch)
          MODE_OFF: lit = 1'b0;
          MODE_ON:  lit = 1'b1;
          default:  lit = (period_cnt_q < duty_q[i]);
        endcase
        led_d[i] = lit ^ INACTIVE;

        if (period_end_c && (mode_ch == MODE_BREATHE)) begin
          if (dir_q[i] == DIR_UP) begin
            if ((duty_ext + STEP_X) >= PERIOD_X) begin
              duty_d[i] = DUTY_MAX;
              dir_d[i]  = DIR_DOWN;
            end else begin
              duty_d[i] = CNT_W'(duty_ext + STEP_X);
            end
          end else begin
            if (duty_ext <= STEP_X) begin
              duty_d[i] = '0;
              dir_d[i]  = DIR_UP;
              if (i == 0) begin
                breath_done_d = 1'b1;
              end
            end else begin
              duty_d[i] = CNT_W'(duty_ext - STEP_X);
            end
          end
        end
      end
    end
  end

  // State registers; reset staggers the starting duty of each channel when enabled.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      period_cnt_q  <= '0;
      dir_q         <= {CH_NUM{DIR_UP}};
      led_q         <= {CH_NUM{INACTIVE}};
      period_tick_q <= 1'b0;
      breath_done_q <= 1'b0;
      for (int i = 0; i < int'(CH_NUM); i++) begin
        duty_q[i] <= (PHASE_EN != 0) ? CNT_W'(PHASE_STEP * i) : '0;
      end
    end else begin
      period_cnt_q  <= period_cnt_d;
      dir_q         <= dir_d;
      led_q         <= led_d;
      period_tick_q <= period_tick_d;
      breath_done_q <= breath_done_d;
      for (int i = 0; i < int'(CH_NUM); i++) begin
        duty_q[i] <= duty_d[i];
      end
    end
  end

  assign led         = led_q;
  assign period_tick = period_tick_q;
  assign breath_done = breath_done_q;

endmodule

// File: tb/tb_breath_led_array.sv
// Directed bench for breath_led_array (PWM_PERIOD=10, STEP=3, CH_NUM=2) with a cycle scoreboard
// and per-period lit-cycle counts checked against hand-derived duty tables.
module tb_breath_led_array;

  localparam int P = 10;
  localparam int S = 3;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       en;
  logic [3:0] mode;
  logic [1:0] led, led_al;
  logic       period_tick, period_tick_al;
  logic       breath_done, breath_done_al;

  typedef struct packed {
    logic [1:0] led;
    logic [1:0] led_al;
    logic       tick;
    logic       done;
  } exp_t;

  exp_t sb_q[$];

  int vectors = 0;
  int errors  = 0;
  int m_cnt;
  int m_duty[2];
  int m_dir[2];
  int c0, c1;
  int done_cnt = 0;
  int done_period = -1;
  int period_idx = 0;

  always #5 sys_clk = ~sys_clk;

  breath_led_array #(
    .CH_NUM(2), .PWM_PERIOD(P), .CNT_W(4), .STEP(S), .PHASE_EN(1), .ACTIVE_LOW(0)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .mode(mode),
    .led(led), .period_tick(period_tick), .breath_done(breath_done)
  );

  breath_led_array #(
    .CH_NUM(2), .PWM_PERIOD(P), .CNT_W(4), .STEP(S), .PHASE_EN(1), .ACTIVE_LOW(1)
  ) dut_al (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .mode(mode),
    .led(led_al), .period_tick(period_tick_al), .breath_done(breath_done_al)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Predict the next edge from the spec-level model, then compare after the edge.
  task automatic step();
    exp_t       e;
    exp_t       got;
    logic [1:0] md;
    bit         endp;
    e = '0;
    if (sys_rst) begin
      m_cnt = 0; m_duty[0] = 0; m_duty[1] = P / 2; m_dir[0] = 0; m_dir[1] = 0;
    end else if (en) begin
      endp   = (m_cnt == P - 1);
      e.tick = endp;
      for (int i = 0; i < 2; i++) begin
        md = mode[2*i +: 2];
        e.led[i] = (md == 2'b01) ? 1'b1 : (md == 2'b00) ? 1'b0 : (m_cnt < m_duty[i]);
        if (endp && md == 2'b10) begin
          if (m_dir[i] == 0) begin
            if (m_duty[i] + S >= P) begin m_duty[i] = P; m_dir[i] = 1; end
            else m_duty[i] = m_duty[i] + S;
          end else begin
            if (m_duty[i] <= S) begin
              m_duty[i] = 0; m_dir[i] = 0;
              if (i == 0) e.done = 1'b1;
            end else m_duty[i] = m_duty[i] - S;
          end
        end
      end
      m_cnt = endp ? 0 : m_cnt + 1;
    end
    e.led_al = ~e.led;
    sb_q.push_back(e);

    @(posedge sys_clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      chk("led", 32'(led), 32'(got.led));
      chk("led_al", 32'(led_al), 32'(got.led_al));
      chk("tick", 32'(period_tick), 32'(got.tick));
      chk("done", 32'(breath_done), 32'(got.done));
    end
    c0 += int'(led[0]);
    c1 += int'(led[1]);
    if (breath_done) begin
      done_cnt++;
      done_period = period_idx;
    end
    @(negedge sys_clk);
  endtask

  // One full PWM period; e1 < 0 skips the ch1 lit count, pause_at >= 0 inserts 3 disabled cycles.
  task automatic run_period(input int e0, input int e1, input int pause_at);
    c0 = 0; c1 = 0;
    for (int k = 0; k < P; k++) begin
      if (k == pause_at) begin
        en = 1'b0;
        step(); step(); step();
        en = 1'b1;
      end
      step();
    end
    chk($sformatf("lit0_p%0d", period_idx), 32'(c0), 32'(e0));
    if (e1 >= 0) chk($sformatf("lit1_p%0d", period_idx), 32'(c1), 32'(e1));
    period_idx++;
  endtask

  initial begin
    int tab0[10];
    int tab1[10];
    tab0 = '{0, 3, 6, 9, 10, 7, 4, 1, 0, 3};
    tab1 = '{5, 8, 10, 7, 4, 1, 0, 3, 6, 9};

    sys_rst = 1'b1; en = 1'b0; mode = 4'b1010;
    step(); step();
    sys_rst = 1'b0; en = 1'b1;

    // Both channels breathing from the staggered reset duties.
    for (int p = 0; p < 10; p++) run_period(tab0[p], tab1[p], -1);
    chk("done_cnt", 32'(done_cnt), 32'd1);
    chk("done_period", 32'(done_period), 32'd7);

    // ch0 frozen at 6, then resumes 9,10,7.
    mode[1:0] = 2'b11;
    run_period(6, -1, -1); run_period(6, -1, -1); run_period(6, -1, -1);
    mode[1:0] = 2'b10;
    run_period(6, -1, -1); run_period(9, -1, -1); run_period(10, -1, -1); run_period(7, -1, -1);

    // ch1 forced off then on while ch0 keeps breathing.
    mode[3:2] = 2'b00; run_period(4, 0, -1);
    mode[3:2] = 2'b01; run_period(1, 10, -1);
    mode[3:2] = 2'b10;
    run_period(0, -1, -1); run_period(3, -1, -1);

    // Global enable dropped with the counter at 4.
    run_period(6, -1, 4);

    // Reset mid-period while ch0 is at duty 9 ramping up.
    c0 = 0; c1 = 0;
    for (int k = 0; k < 5; k++) step();
    sys_rst = 1'b1;
    step();
    chk("rst_led_al", 32'(led_al), 32'h3);
    chk("rst_led", 32'(led), 32'h0);
    sys_rst = 1'b0;
    run_period(0, 5, -1);
    run_period(3, 8, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
